// File: rtl/imm_enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_enc_pkg                                                          |
// | Format selects, RV32I opcodes and request type for immediate_encoder |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package imm_enc_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  typedef struct packed {
    logic [2:0]  imm_src;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } imm_req_t;

endpackage
`default_nettype wire

// File: rtl/imm_scatter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_scatter                                                          |
// | Combinational field placement and immediate range check              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imm_scatter
  import imm_enc_pkg::*;
(
  input  imm_req_t    req_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic [31:0] w_imm;
  assign w_imm = req_i.imm;

  // Range checks are sign-extension tests: the immediate must equal the
  // sign extension of its encodable field width.
  always_comb begin
    instr_o = {25'b0, req_i.opcode};
    err_o   = 1'b1;
    case (req_i.imm_src)
      IMM_I: begin
        instr_o = {w_imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
        err_o   = (w_imm[31:11] != {21{w_imm[11]}});
      end
      IMM_S: begin
        instr_o = {w_imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3,
                   w_imm[4:0], req_i.opcode};
        err_o   = (w_imm[31:11] != {21{w_imm[11]}});
      end
      IMM_B: begin
        instr_o = {w_imm[12], w_imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                   w_imm[4:1], w_imm[11], req_i.opcode};
        err_o   = (w_imm[31:12] != {20{w_imm[12]}}) || w_imm[0];
      end
      IMM_U: begin
        instr_o = {w_imm[31:12], req_i.rd, req_i.opcode};
        err_o   = (w_imm[11:0] != 12'd0);
      end
      IMM_J: begin
        instr_o = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                   req_i.rd, req_i.opcode};
        err_o   = (w_imm[31:20] != {12{w_imm[20]}}) || w_imm[0];
      end
      default: begin
        instr_o = {25'b0, req_i.opcode};
        err_o   = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/immediate_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | immediate_encoder                                                    |
// | Two-stage valid/ready RV32I instruction assembler with error counter |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module immediate_encoder
  import imm_enc_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_imm_src,
  input  logic [31:0]          in_imm,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [2:0]           in_funct3,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic                 s1_valid_q, s1_valid_d;
  imm_req_t             s1_req_q, s1_req_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_instr_q, out_instr_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 w_s2_adv;
  logic                 w_in_fire;
  logic                 w_out_fire;
  imm_req_t             w_in_req;
  logic [31:0]          w_scat_instr;
  logic                 w_scat_err;

  assign w_in_req = '{imm_src: in_imm_src, imm: in_imm, opcode: in_opcode,
                      rd: in_rd, funct3: in_funct3, rs1: in_rs1, rs2: in_rs2};

  assign w_s2_adv   = !out_valid_q || out_ready;
  assign in_ready   = !rst && !flush && (!s1_valid_q || w_s2_adv);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid_q && out_ready;

  imm_scatter u_scatter (
    .req_i   (s1_req_q),
    .instr_o (w_scat_instr),
    .err_o   (w_scat_err)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_req_d    = s1_req_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;

    // A result delivered in a flush cycle still counts; flush only drops
    // what remains in flight.
    if (w_out_fire && out_err_q && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (w_s2_adv) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          out_instr_d = w_scat_instr;
          out_err_d   = w_scat_err;
        end
        s1_valid_d = 1'b0;
      end
      if (w_in_fire) begin
        s1_valid_d = 1'b1;
        s1_req_d   = w_in_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire
